// File: rtl/overcurrent_pkg.sv
// Shared state encoding, bridge constants and a saturating trip counter helper
// for the overcurrent supervisor.
package overcurrent_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COOLDOWN = 2'd2,
    LOCKOUT  = 2'd3
  } oc_state_t;

  localparam logic [1:0] MOTOR_COAST = 2'b00;

  function automatic logic [1:0] sat_inc2(input logic [1:0] value, input logic [1:0] limit);
    logic [1:0] result;
    if (value >= limit) begin
      result = limit;
    end else begin
      result = value + 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/overcurrent_supervisor_debounce.sv
// Overcurrent debounce: emits a one-cycle trip strobe on the DEBOUNCE-th
// consecutive enabled cycle with the overcurrent flag asserted.
module oc_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic over,
  input  logic enable,
  output logic trip
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);

  logic [DW-1:0] deb_cnt_r;

  assign trip = enable & over & (deb_cnt_r == LAST);

  // Consecutive-overcurrent counter; any clean or disabled cycle restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_r <= '0;
    end else if (enable && over && !trip) begin
      deb_cnt_r <= deb_cnt_r + DW'(1);
    end else begin
      deb_cnt_r <= '0;
    end
  end

endmodule

// File: rtl/overcurrent_supervisor.sv
// Motor-drive supervisor: trips the H-bridge off on debounced overcurrent,
// cools down and retries, and latches a lockout after repeated trips.
module overcurrent_supervisor
  import overcurrent_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int COOL_CYCLES = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int GOOD_CYCLES = 50000,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Overx,
  input  logic       Underx,
  input  logic       drive_req,
  input  logic [1:0] dir_req,
  input  logic       clear_fault,
  output logic       EnA,
  output logic [1:0] Motorx,
  output logic       fault,
  output logic       lockout,
  output logic [1:0] trip_count
);

  localparam logic [CW-1:0] COOL_LIMIT = CW'(COOL_CYCLES);
  localparam logic [CW-1:0] GOOD_LIMIT = CW'(GOOD_CYCLES);
  localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRY);

  oc_state_t     state_r, state_s;
  logic [CW-1:0] cool_cnt_r, cool_cnt_s;
  logic [CW-1:0] good_cnt_r, good_cnt_s;
  logic [1:0]    trip_cnt_r, trip_cnt_s;
  logic [1:0]    motor_r, motor_s;
  logic          en_r, fault_r, lockout_r;
  logic          trip_s;
  logic          under_ok_s;

  // Both comparator flags high is an invalid reading and is treated as overcurrent
  assign under_ok_s = Underx & ~Overx;

  oc_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .over   (Overx),
    .enable (state_r == RUN),
    .trip   (trip_s)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_s    = state_r;
    cool_cnt_s = cool_cnt_r;
    good_cnt_s = good_cnt_r;
    trip_cnt_s = trip_cnt_r;
    motor_s    = MOTOR_COAST;
    case (state_r)
      IDLE: begin
        if (drive_req && !Overx) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (trip_s) begin
          trip_cnt_s = sat_inc2(trip_cnt_r, RETRY_LIMIT);
          good_cnt_s = '0;
          cool_cnt_s = '0;
          if (trip_cnt_s == RETRY_LIMIT) begin
            state_s = LOCKOUT;
          end else begin
            state_s = COOLDOWN;
          end
        end else if (!drive_req) begin
          state_s    = IDLE;
          good_cnt_s = '0;
        end else if (!Overx) begin
          if (good_cnt_r < GOOD_LIMIT) begin
            good_cnt_s = good_cnt_r + CW'(1);
          end else begin
            good_cnt_s = good_cnt_r;
          end
          // A long enough clean run forgives earlier trips
          if (good_cnt_s == GOOD_LIMIT) begin
            trip_cnt_s = 2'd0;
          end else begin
            trip_cnt_s = trip_cnt_r;
          end
        end else begin
          good_cnt_s = good_cnt_r;
        end
      end
      COOLDOWN: begin
        if (cool_cnt_r == COOL_LIMIT && under_ok_s) begin
          cool_cnt_s = '0;
          if (drive_req) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end else if (cool_cnt_r < COOL_LIMIT) begin
          cool_cnt_s = cool_cnt_r + CW'(1);
        end else begin
          cool_cnt_s = cool_cnt_r;
        end
      end
      LOCKOUT: begin
        if (clear_fault && !drive_req) begin
          state_s    = IDLE;
          trip_cnt_s = 2'd0;
        end else begin
          state_s = LOCKOUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (state_s == RUN) begin
      motor_s = dir_req;
    end else begin
      motor_s = MOTOR_COAST;
    end
  end

  // State, counters and registered bridge/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cool_cnt_r <= '0;
      good_cnt_r <= '0;
      trip_cnt_r <= 2'd0;
      motor_r    <= MOTOR_COAST;
      en_r       <= 1'b0;
      fault_r    <= 1'b0;
      lockout_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cool_cnt_r <= cool_cnt_s;
      good_cnt_r <= good_cnt_s;
      trip_cnt_r <= trip_cnt_s;
      motor_r    <= motor_s;
      en_r       <= (state_s == RUN);
      fault_r    <= (state_s == COOLDOWN) || (state_s == LOCKOUT);
      lockout_r  <= (state_s == LOCKOUT);
    end
  end

  assign EnA        = en_r;
  assign Motorx     = motor_r;
  assign fault      = fault_r;
  assign lockout    = lockout_r;
  assign trip_count = trip_cnt_r;

endmodule

// File: tb/tb_overcurrent_supervisor.sv
// Directed bench for overcurrent_supervisor: a behavioural model checked every
// cycle, plus hand-computed expectations for timing and key status values.
module tb_overcurrent_supervisor;

  localparam int DEB  = 4;
  localparam int COOL = 20;
  localparam int MAXR = 3;
  localparam int GOOD = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Overx = 1'b0, Underx = 1'b0, drive_req = 1'b0, clear_fault = 1'b0;
  logic [1:0] dir_req = 2'b00;
  logic       EnA, fault, lockout;
  logic [1:0] Motorx, trip_count;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  overcurrent_supervisor #(
    .DEBOUNCE(DEB), .COOL_CYCLES(COOL), .MAX_RETRY(MAXR), .GOOD_CYCLES(GOOD), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .Overx(Overx), .Underx(Underx), .drive_req(drive_req),
    .dir_req(dir_req), .clear_fault(clear_fault), .EnA(EnA), .Motorx(Motorx),
    .fault(fault), .lockout(lockout), .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        running;
    logic        cooling;
    logic        locked;
    logic [1:0]  motor;
    logic [31:0] streak;
    logic [31:0] cooled;
    logic [31:0] good;
    logic [31:0] trips;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input logic ov, input logic un,
                                        input logic drv, input logic [1:0] dir,
                                        input logic clr);
    model_t n = s;
    logic recovered = un && !ov;
    if (s.running) begin
      if ((ov ? s.streak + 1 : 0) >= DEB) begin
        n.trips   = (s.trips + 1 > MAXR) ? MAXR : s.trips + 1;
        n.running = 1'b0;
        n.locked  = (n.trips == MAXR);
        n.cooling = !n.locked;
        n.cooled  = 0;
        n.good    = 0;
        n.streak  = 0;
      end else if (!drv) begin
        n.running = 1'b0;
        n.good    = 0;
        n.streak  = 0;
      end else begin
        n.streak = ov ? s.streak + 1 : 0;
        n.motor  = dir;
        if (!ov) begin
          n.good = (s.good + 1 > GOOD) ? GOOD : s.good + 1;
          if (n.good == GOOD) n.trips = 0;
        end
      end
    end else if (s.cooling) begin
      if (s.cooled == COOL && recovered) begin
        n.cooling = 1'b0;
        n.cooled  = 0;
        n.running = drv;
        n.motor   = dir;
        n.streak  = 0;
      end else begin
        n.cooled = (s.cooled + 1 > COOL) ? COOL : s.cooled + 1;
      end
    end else if (s.locked) begin
      if (clr && !drv) begin
        n.locked = 1'b0;
        n.trips  = 0;
      end
    end else if (drv && !ov) begin
      n.running = 1'b1;
      n.motor   = dir;
      n.streak  = 0;
      n.good    = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, Overx, Underx, drive_req, dir_req, clear_fault);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("EnA", 32'(EnA), 32'(m.running));
      check("Motorx", 32'(Motorx), m.running ? 32'(m.motor) : 32'd0);
      check("fault", 32'(fault), 32'(m.cooling | m.locked));
      check("lockout", 32'(lockout), 32'(m.locked));
      check("trip_count", 32'(trip_count), m.trips);
    end
  end

  // Raise Overx and report how many edges pass before EnA drops
  task automatic do_trip(output int edges);
    edges = 0;
    @(negedge clk) Overx = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (!EnA) begin
        edges = k;
        break;
      end
    end
    @(negedge clk) Overx = 1'b0;
  endtask

  task automatic recover();
    bit ok = 1'b0;
    @(negedge clk) Underx = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (EnA) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("recover_timeout", 32'd0, 32'd1);
    @(negedge clk) Underx = 1'b0;
  endtask

  initial begin
    int edges;
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_EnA", 32'(EnA), 32'd0);
    check("reset_trip_count", 32'(trip_count), 32'd0);

    // Run forward, short overcurrent burst does not trip
    drive_req = 1'b1;
    dir_req = 2'b01;
    repeat (3) @(negedge clk);
    check("run_EnA", 32'(EnA), 32'd1);
    check("run_Motorx", 32'(Motorx), 32'd1);
    Overx = 1'b1;
    repeat (3) @(negedge clk);
    Overx = 1'b0;
    repeat (2) @(negedge clk);
    check("burst3_no_trip", 32'(EnA), 32'd1);

    do_trip(edges);
    check("trip_edges", 32'(edges), 32'd4);
    check("trip1_fault", 32'(fault), 32'd1);
    check("trip1_count", 32'(trip_count), 32'd1);

    // Cooldown with Underx arriving at cycle 5: retry on edge 21
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) Underx = 1'b1;
      @(posedge clk); #1;
      if (EnA) begin
        n = k + 1;
        break;
      end
    end
    check("cool_retry_edge", 32'(n), 32'd21);
    check("retry_Motorx", 32'(Motorx), 32'd1);
    @(negedge clk) Underx = 1'b0;

    // Second trip, Underx low past the cooldown keeps the drive off
    do_trip(edges);
    repeat (30) @(negedge clk);
    check("cool_hold_EnA", 32'(EnA), 32'd0);
    check("cool_hold_fault", 32'(fault), 32'd1);
    recover();
    check("trip2_count", 32'(trip_count), 32'd2);

    // Asynchronous reset in the middle of a run cycle
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async_EnA", 32'(EnA), 32'd0);
    check("async_Motorx", 32'(Motorx), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_trip_count", 32'(trip_count), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Three trips latch lockout; clear needs drive_req low
    repeat (2) @(negedge clk);
    do_trip(edges);
    recover();
    do_trip(edges);
    recover();
    do_trip(edges);
    check("lock_lockout", 32'(lockout), 32'd1);
    check("lock_count", 32'(trip_count), 32'd3);
    clear_fault = 1'b1;
    repeat (3) @(negedge clk);
    check("lock_clear_ignored", 32'(lockout), 32'd1);
    drive_req = 1'b0;
    @(posedge clk); #1;
    check("lock_cleared", 32'(lockout), 32'd0);
    check("lock_cleared_count", 32'(trip_count), 32'd0);
    @(negedge clk) clear_fault = 1'b0;

    // Start request under overcurrent waits in idle
    drive_req = 1'b1;
    dir_req = 2'b10;
    Overx = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_blocked", 32'(EnA), 32'd0);
    Overx = 1'b0;
    @(posedge clk); #1;
    check("idle_start_Motorx", 32'(Motorx), 32'd2);

    // Good run forgives two trips
    do_trip(edges);
    recover();
    do_trip(edges);
    recover();
    repeat (105) @(negedge clk);
    check("good_clear", 32'(trip_count), 32'd0);
    do_trip(edges);
    check("good_next_lockout", 32'(lockout), 32'd0);
    check("good_next_count", 32'(trip_count), 32'd1);
    recover();

    // Invalid comparator state trips, and wins over drive_req dropping
    @(negedge clk) begin
      Overx = 1'b1;
      Underx = 1'b1;
    end
    repeat (3) @(negedge clk);
    drive_req = 1'b0;
    @(posedge clk); #1;
    check("inv_EnA", 32'(EnA), 32'd0);
    check("inv_fault", 32'(fault), 32'd1);
    check("inv_count", 32'(trip_count), 32'd2);
    repeat (30) @(negedge clk);
    check("inv_hold_fault", 32'(fault), 32'd1);
    Overx = 1'b0;
    repeat (2) @(negedge clk);
    check("cool_to_idle_fault", 32'(fault), 32'd0);
    check("cool_to_idle_EnA", 32'(EnA), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
